noc_input_port_queue: RTL
=========================

Name: noc_input_port_queue

Overview:
Parametrised router input-port flit queue, the successor to the fixed 4-deep port queue. It supports both NoC flow-control modes, selected by a parameter: ack/nack back-pressure, or credit return. It tracks wormhole packet state from the head/tail preamble and flags overflow and protocol errors. One instance sits on each enabled router port, between the link and the crossbar arbiter.

Parameters:
FlowControl, kFlowControlCreditBased, noc_flow_control_t; selects ack/nack (stop_out) or credit-based (credit_out) operation.
DataWidth, 64, flit width in bits; preamble {head,tail} occupies bits [DataWidth-1:DataWidth-2].
Depth, PortQueueDepth (4), queue entries; any value >=1, not restricted to powers of two.
CountWidth, $clog2(Depth+1), occupancy counter width; derived, not overridden.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
data_in  in  DataWidth  incoming flit
data_void_in  in  1  1 = no flit on data_in this cycle
stop_out  out  1  ack/nack back-pressure to upstream; tied 0 in credit mode
credit_out  out  1  one-cycle credit-return pulse to upstream; tied 0 in ack/nack mode
data_out  out  DataWidth  flit at queue head
data_void_out  out  1  1 = queue empty, data_out invalid
stop_in  in  1  downstream (crossbar) not accepting this cycle
in_packet_out  out  1  wormhole packet in progress (head dequeued, tail not yet)
level_out  out  CountWidth  current occupancy
overflow_err_out  out  1  sticky: write attempted while full
proto_err_out  out  1  sticky: head dequeued while in_packet_out=1, or body/tail dequeued while in_packet_out=0

Behaviour:
- Reset (rst=0, async): count=0, rd/wr pointers=0. Outputs: data_void_out=1, stop_out=0, credit_out=0, in_packet_out=0, level_out=0, both error flags=0. data_out is don't-care.
- push_req = !data_void_in. full = (count==Depth).
- Ack/nack mode: stop_out = full, registered (a function of count only). A write is accepted when push_req && !full; push_req while full is ignored without error, because the upstream must hold the flit.
- Credit mode: the upstream starts with Depth credits. A write is accepted when push_req && !full. push_req while full drops the flit and sets overflow_err_out, even if a pop happens in the same cycle.
- Pop: when !empty && !stop_in. data_out and data_void_out are combinational from storage and count; first-word latency is 1 cycle (written flit visible the cycle after the write).
- Simultaneous push and pop when 0<count<Depth: count unchanged, both pointers advance.
- Pointers wrap explicitly from Depth-1 to 0.
- credit_out: registered; asserts exactly 1 cycle after each pop (one pulse per popped flit, back-to-back pulses allowed).
- Packet FSM (IDLE, BODY), advancing on pop only:
  - IDLE: head & !tail -> BODY. head & tail -> stay IDLE (single-flit packet). !head -> proto_err_out, stay IDLE.
  - BODY: tail & !head -> IDLE. head -> proto_err_out, stay BODY. No preamble bits -> stay BODY.
  - in_packet_out = (state==BODY).
- Error flags clear only on reset.
- level_out = count, registered.

Decomposition:
- In shared package noc: flit_preamble_msb = DataWidth-1 helper function get_preamble(flit) returning preamble_t; packet-state enum (kPktIdle, kPktBody); noc_flow_control_t and PortQueueDepth are reused.
- Sub-module noc_queue_storage: Depth x DataWidth register array with wr_en/wr_ptr/rd_ptr and combinational read. Pointer, count, flow-control and FSM logic stay in the top.

Test Plan:
1. Credit mode, Depth=4: 4 flits pushed, stop_in=1 -> level_out=4, credit_out=0. Release stop_in -> 4 pops in consecutive cycles, credit_out high on 4 consecutive cycles, each one cycle after its pop.
2. Credit mode, full, push with simultaneous pop -> flit dropped, overflow_err_out=1 and stays high, level_out=3 next cycle.
3. Ack/nack mode, Depth=3: stream of 5 flits with stop_in=1 -> stop_out=1 after the 3rd accept, flits 4-5 held upstream. Release stop_in -> all 5 flits emerge in order, no error.
4. Packet: pop head(10), body(00), body(00), tail(01) -> in_packet_out 1 from the cycle after the head pop until the cycle after the tail pop. Single-flit 11 -> in_packet_out stays 0.
5. Protocol: pop head(10) then head(10) -> proto_err_out=1. Body flit 00 popped at IDLE after reset -> proto_err_out=1.
6. Depth=5 non-power-of-two: 12 flits streamed with random stop_in -> order preserved across pointer wrap. Assert rst mid-stream -> all outputs at reset values within the same cycle, queue empty.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types: flow-control mode, packet state and flit preamble decoding.
package noc_pkg;

  typedef enum logic {
    kFlowControlAckNack,
    kFlowControlCreditBased
  } noc_flow_control_t;

  localparam int unsigned PortQueueDepth = 4;

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  typedef enum logic {
    kPktIdle,
    kPktBody
  } pkt_state_t;

  // Takes the two flit MSBs, {head, tail}.
  function automatic preamble_t get_preamble(input logic [1:0] msbs);
    return preamble_t'(msbs);
  endfunction

endpackage

// File: rtl/noc_queue_storage.sv
// Depth x DataWidth flit register array with one write port and a combinational read port.
module noc_queue_storage #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned PtrWidth  = 2
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [PtrWidth-1:0]  wr_ptr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic [PtrWidth-1:0]  rd_ptr_i,
  output logic [DataWidth-1:0] rd_data_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/noc_input_port_queue.sv
// Router input-port flit queue with ack/nack or credit flow control and wormhole tracking.
module noc_input_port_queue
  import noc_pkg::*;
#(
  parameter noc_flow_control_t FlowControl = kFlowControlCreditBased,
  parameter int unsigned       DataWidth   = 64,
  parameter int unsigned       Depth       = PortQueueDepth,
  localparam int unsigned      CountWidth  = $clog2(Depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DataWidth-1:0]  data_in,
  input  logic                  data_void_in,
  output logic                  stop_out,
  output logic                  credit_out,
  output logic [DataWidth-1:0]  data_out,
  output logic                  data_void_out,
  input  logic                  stop_in,
  output logic                  in_packet_out,
  output logic [CountWidth-1:0] level_out,
  output logic                  overflow_err_out,
  output logic                  proto_err_out
);

  localparam int unsigned PtrWidth    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PreambleMsb = DataWidth - 1;
  localparam logic        IsCredit    = (FlowControl == kFlowControlCreditBased);

  logic [CountWidth-1:0] count_q, count_d;
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  pkt_state_t            state_q, state_d;
  logic                  credit_q;
  logic                  overflow_q, overflow_d;
  logic                  proto_q, proto_d;
  logic [DataWidth-1:0]  rd_data;
  preamble_t             pre;
  logic                  full, empty, push_req, wr_en, pop;

  assign full     = (count_q == CountWidth'(Depth));
  assign empty    = (count_q == '0);
  assign push_req = !data_void_in;
  assign wr_en    = push_req && !full;
  assign pop      = !empty && !stop_in;
  assign pre      = get_preamble(rd_data[PreambleMsb -: 2]);

  noc_queue_storage #(
    .Depth     (Depth),
    .DataWidth (DataWidth),
    .PtrWidth  (PtrWidth)
  ) u_storage (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CountWidth'(1);
      2'b01:   count_d = count_q - CountWidth'(1);
      default: count_d = count_q;
    endcase
    // In credit mode a flit arriving while full is lost, even if a pop frees a slot.
    if (IsCredit && push_req && full) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    proto_d = proto_q;
    if (pop) begin
      unique case (state_q)
        kPktIdle: begin
          if (pre.head && !pre.tail) begin
            state_d = kPktBody;
          end else if (!pre.head) begin
            proto_d = 1'b1;
          end
        end
        kPktBody: begin
          if (pre.head) begin
            proto_d = 1'b1;
          end else if (pre.tail) begin
            state_d = kPktIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= kPktIdle;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      credit_q   <= IsCredit && pop;
      overflow_q <= overflow_d;
      proto_q    <= proto_d;
    end
  end

  assign stop_out         = !IsCredit && full;
  assign credit_out       = credit_q;
  assign data_out         = rd_data;
  assign data_void_out    = empty;
  assign in_packet_out    = (state_q == kPktBody);
  assign level_out        = count_q;
  assign overflow_err_out = overflow_q;
  assign proto_err_out    = proto_q;

endmodule
